mem_access_arbiter: RTL
=======================

Name: mem_access_arbiter

Overview:
- Shares the single memory port between the instruction-fetch path (control unit fetch states) and the load/store data path.
- Sequences each access with the MFA/MOC handshake and returns read data and a completion pulse to the winning requester.
- Bounds every access with a timeout and flags a bus error.
- Sits between the control unit / datapath and the memory model. The control unit's MOC-wait states consume its done outputs.

Parameters:
- TIMEOUT_CYCLES, 15: maximum number of ACCESS cycles before a bus error is declared; legal range 2..255.
- ADDR_W, 32: address width.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- CLR  in  1  synchronous, active-high reset.
- fetch_req  in  1  level request from the fetch path; held until fetch_done.
- fetch_addr  in  ADDR_W  fetch address (PC).
- data_req  in  1  level request from the load/store path; held until data_done.
- data_addr  in  ADDR_W  load/store effective address.
- data_rw  in  1  1 = write (store), 0 = read (load).
- data_byte  in  1  1 = byte access, 0 = word.
- data_wdata  in  32  store data.
- mem_mfa  out  1  memory function active.
- mem_addr  out  ADDR_W  latched address.
- mem_rw  out  1  latched direction.
- mem_byte  out  1  latched size.
- mem_wdata  out  32  latched store data.
- mem_moc  in  1  memory operation complete.
- mem_rdata  in  32  memory read data.
- fetch_done  out  1  one-cycle completion pulse to the fetch path.
- data_done  out  1  one-cycle completion pulse to the data path.
- rdata  out  32  registered read data, valid while either done is high.
- bus_error  out  1  one-cycle pulse, coincident with the done pulse, on timeout.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (CLR high at an edge):
  - state = IDLE, last_grant = DATA, timeout counter = 0.
  - All outputs 0, including mem_addr, mem_wdata and rdata.
  - CLR mid-access drops mem_mfa at that edge. No done or error pulse is issued, and the aborted access is not replayed.
- States are IDLE, ACCESS and RELEASE.
- IDLE:
  - If neither request is asserted, stay in IDLE.
  - If only one request is asserted, grant it.
  - If both are asserted, grant the one not in last_grant (alternation).
  - On a grant: latch address and controls into mem_* and set last_grant. Fetch is always a word read (mem_rw = 0, mem_byte = 0, mem_wdata unchanged).
  - Go to ACCESS. mem_mfa goes high in the cycle after the request was sampled.
- ACCESS:
  - mem_mfa = 1, and mem_* stay stable for the whole state.
  - The counter increments on every ACCESS cycle in which mem_moc = 0.
  - mem_moc = 1:
    - For a read, latch mem_rdata into rdata. For a write, rdata is unchanged.
    - Go to RELEASE.
  - mem_moc = 0 with counter == TIMEOUT_CYCLES-1:
    - Go to RELEASE with error flagged, rdata = 32'hFFFF_FFFF.
    - ACCESS therefore lasts at most TIMEOUT_CYCLES cycles.
  - mem_moc and timeout in the same cycle: MOC wins, no error.
- RELEASE:
  - Exactly one cycle.
  - mem_mfa = 0 and busy = 1.
  - The granted requester's done = 1, and bus_error = 1 if flagged.
  - Requests are ignored.
  - Go to IDLE and clear the counter.
- Requester contract: req drops at the edge where done is sampled, so req is low in the following IDLE cycle. A req still high in IDLE is treated as a new request.
- Latency:
  - Request sampled at cycle N, MOC at cycle N+k (k ≥ 1): done at N+k+1, earliest next mem_mfa at N+k+3.
  - The minimum round trip is 3 cycles.
- mem_moc outside ACCESS is ignored.
- Request inputs and data_* may change freely outside IDLE sampling; latched values are used.
- fetch_done and data_done are never high together.

Decomposition:
- Shared control-unit package holds:
  - State encodings: IDLE = 2'd0, ACCESS = 2'd1, RELEASE = 2'd2.
  - Grant encoding: FETCH = 1'b0, DATA = 1'b1.
  - The RW and byte/word codes shared with the datapath.
  - The bus-error fill constant 32'hFFFF_FFFF.
- One sub-module, access_timeout_counter: clear/increment/expire, width $clog2(TIMEOUT_CYCLES). The FSM and arbitration stay in the top level.

Test Plan:
- Reset then fetch_req with fetch_addr = 32'h0000_0040; memory returns MOC 2 cycles after MFA with rdata 32'hE3A0_1005:
  - mem_mfa is high for exactly 2 cycles.
  - fetch_done pulses once with rdata = 32'hE3A0_1005.
  - bus_error stays 0.
- Both requests asserted after reset; data_addr = 32'h100, data_rw = 1, data_wdata = 32'hDEAD_BEEF:
  - Fetch is granted first (last_grant reset = DATA).
  - Then data is granted with mem_rw = 1 and mem_wdata = 32'hDEAD_BEEF.
  - Then, with both re-asserted, fetch is granted again.
- Byte load with data_byte = 1 at data_addr = 32'h103: mem_byte = 1 for the whole ACCESS, data_done pulses, fetch_done stays 0.
- MOC never asserted, TIMEOUT_CYCLES = 15:
  - mem_mfa is high for exactly 15 cycles.
  - data_done and bus_error pulse together with rdata = 32'hFFFF_FFFF.
  - busy returns to 0 next cycle.
- MOC asserted on the 15th ACCESS cycle: normal completion, bus_error = 0.
- CLR raised on the 2nd ACCESS cycle of a fetch:
  - mem_mfa = 0 at the next edge, with no done or error pulse.
  - After CLR falls, a held fetch_req is re-granted and mem_mfa rises one cycle later.

Source files
------------

// File: rtl/mem_access_arbiter_pkg.sv
// Shared control-unit codes: arbiter state encodings, grant identities,
// the access direction/size codes shared with the datapath, and the bus-error fill word.
package mem_access_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_e;

    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;
    localparam logic SIZE_WORD = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;

    localparam logic [31:0] BUS_ERR_FILL = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_access_arbiter_access_timeout_counter.sv
// Counts ACCESS cycles without MOC; o_expire flags the last cycle the access may
// still wait for memory before it is abandoned with a bus error.
module access_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic i_clk,
    input  logic i_srst,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_srst || i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_expire = (r_count == LAST_COUNT);

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates the single memory port between instruction fetch and load/store,
// running each access through IDLE -> ACCESS -> RELEASE with an MFA/MOC handshake.
module mem_access_arbiter
    import mem_access_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int ADDR_W         = 32
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              data_req,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic              data_rw,
    input  logic              data_byte,
    input  logic [31:0]       data_wdata,
    output logic              mem_mfa,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rw,
    output logic              mem_byte,
    output logic [31:0]       mem_wdata,
    input  logic              mem_moc,
    input  logic [31:0]       mem_rdata,
    output logic              fetch_done,
    output logic              data_done,
    output logic [31:0]       rdata,
    output logic              bus_error,
    output logic              busy
);

    logic [1:0]        r_state;
    grant_e            r_last_grant;
    logic              r_mfa;
    logic [ADDR_W-1:0] r_addr;
    logic              r_rw;
    logic              r_byte;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_fetch_done;
    logic              r_data_done;
    logic              r_bus_error;

    logic   w_any_req;
    grant_e w_grant;
    logic   w_expire;
    logic   w_cnt_clear;
    logic   w_cnt_inc;

    // On contention the requester that did not win last time goes next.
    assign w_any_req = fetch_req | data_req;
    assign w_grant   = (fetch_req && data_req) ?
                       ((r_last_grant == GRANT_DATA) ? GRANT_FETCH : GRANT_DATA) :
                       (data_req ? GRANT_DATA : GRANT_FETCH);

    assign w_cnt_clear = (r_state == ST_RELEASE);
    assign w_cnt_inc   = (r_state == ST_ACCESS) && !mem_moc;

    access_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (CLK),
        .i_srst   (CLR),
        .i_clear  (w_cnt_clear),
        .i_inc    (w_cnt_inc),
        .o_expire (w_expire)
    );

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GRANT_DATA;
            r_mfa        <= 1'b0;
            r_addr       <= '0;
            r_rw         <= RW_READ;
            r_byte       <= SIZE_WORD;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_fetch_done <= 1'b0;
            r_data_done  <= 1'b0;
            r_bus_error  <= 1'b0;
        end else begin
            r_fetch_done <= 1'b0;
            r_data_done  <= 1'b0;
            r_bus_error  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= ST_ACCESS;
                        r_mfa        <= 1'b1;
                        r_last_grant <= w_grant;
                        if (w_grant == GRANT_DATA) begin
                            r_addr  <= data_addr;
                            r_rw    <= data_rw ? RW_WRITE : RW_READ;
                            r_byte  <= data_byte ? SIZE_BYTE : SIZE_WORD;
                            r_wdata <= data_wdata;
                        end else begin
                            // Fetch is always a word read; store data is left alone.
                            r_addr <= fetch_addr;
                            r_rw   <= RW_READ;
                            r_byte <= SIZE_WORD;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_moc || w_expire) begin
                        r_state      <= ST_RELEASE;
                        r_mfa        <= 1'b0;
                        r_fetch_done <= (r_last_grant == GRANT_FETCH);
                        r_data_done  <= (r_last_grant == GRANT_DATA);
                        // MOC on the expiry cycle still counts as a normal completion.
                        if (mem_moc) begin
                            if (r_rw == RW_READ) begin
                                r_rdata <= mem_rdata;
                            end
                        end else begin
                            r_rdata     <= BUS_ERR_FILL;
                            r_bus_error <= 1'b1;
                        end
                    end
                end
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_mfa    = r_mfa;
    assign mem_addr   = r_addr;
    assign mem_rw     = r_rw;
    assign mem_byte   = r_byte;
    assign mem_wdata  = r_wdata;
    assign fetch_done = r_fetch_done;
    assign data_done  = r_data_done;
    assign rdata      = r_rdata;
    assign bus_error  = r_bus_error;
    assign busy       = (r_state != ST_IDLE);

endmodule
